clock_monitor: RTL and testbench

Synchronous clock/strobe monitor. It samples an asynchronous square-wave input `mon_in` in the `clk` domain and measures the high-phase length and period in `clk` cycles. It tracks minimum and maximum period and flags a stuck input. Used in the template-matching system and its benches to check the simulation clock source, pixel strobes and other periodic signals against expected rates. It is synthesizable RTL.

---
 rtl/clock_monitor.sv | 164 ++++++++++++++++
 tb/tb_clock_monitor.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_monitor.sv
// Clock/strobe monitor: synchronizes mon_in, measures high-phase length and
// period in clk cycles, tracks min/max period and flags a stuck input.
module clock_monitor #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_in,
  input  logic             clr,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W:0]   period,
  output logic [CNT_W:0]   period_min,
  output logic [CNT_W:0]   period_max,
  output logic [CNT_W-1:0] meas_cnt,
  output logic             stuck,
  output logic             stuck_level
);

  localparam int unsigned PW = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_STUCK
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
  logic [CNT_W-1:0] high_tmp_q, high_tmp_d;
  logic             meas_valid_q, meas_valid_d;
  logic [CNT_W-1:0] high_len_q, high_len_d;
  logic [PW-1:0]    period_q, period_d;
  logic [PW-1:0]    period_min_q, period_min_d;
  logic [PW-1:0]    period_max_q, period_max_d;
  logic [CNT_W-1:0] meas_cnt_q, meas_cnt_d;
  logic             stuck_q, stuck_d;
  logic             stuck_level_q, stuck_level_d;

  logic             rise, fall, timeout_hit;
  logic [PW-1:0]    new_period;

  assign rise        = s2_q & ~prev_q;
  assign fall        = ~s2_q & prev_q;
  // An edge in the same cycle always takes priority over the timeout.
  assign timeout_hit = (phase_cnt_q == TIMEOUT_C) && !rise && !fall;
  assign new_period  = PW'(high_tmp_q) + PW'(phase_cnt_q);

  always_comb begin
    s1_d          = mon_in;
    s2_d          = s1_q;
    prev_d        = s2_q;
    state_d       = state_q;
    high_tmp_d    = high_tmp_q;
    meas_valid_d  = 1'b0;
    high_len_d    = high_len_q;
    period_d      = period_q;
    stuck_d       = stuck_q;
    stuck_level_d = stuck_level_q;
    phase_cnt_d   = (phase_cnt_q == CNT_MAX) ? phase_cnt_q : phase_cnt_q + CNT_W'(1);
    if (rise || fall) phase_cnt_d = CNT_W'(1);

    // Clear is applied first so a coincident measurement lands on fresh stats.
    if (clr) begin
      period_min_d = '1;
      period_max_d = '0;
      meas_cnt_d   = '0;
    end else begin
      period_min_d = period_min_q;
      period_max_d = period_max_q;
      meas_cnt_d   = meas_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (fall) begin
          high_tmp_d = phase_cnt_q;
          state_d    = ST_LOW;
        end
      end
      ST_LOW: begin
        if (rise) begin
          high_len_d   = high_tmp_q;
          period_d     = new_period;
          meas_valid_d = 1'b1;
          if (new_period < period_min_d) period_min_d = new_period;
          if (new_period > period_max_d) period_max_d = new_period;
          if (meas_cnt_d != CNT_MAX) meas_cnt_d = meas_cnt_d + CNT_W'(1);
          state_d      = ST_HIGH;
        end
      end
      ST_STUCK: begin
        if (rise) begin
          stuck_d = 1'b0;
          state_d = ST_HIGH;
        end else if (fall) begin
          stuck_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_STUCK && timeout_hit) begin
      state_d       = ST_STUCK;
      stuck_d       = 1'b1;
      stuck_level_d = s2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      prev_q        <= 1'b0;
      phase_cnt_q   <= '0;
      high_tmp_q    <= '0;
      meas_valid_q  <= 1'b0;
      high_len_q    <= '0;
      period_q      <= '0;
      period_min_q  <= '1;
      period_max_q  <= '0;
      meas_cnt_q    <= '0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      prev_q        <= prev_d;
      phase_cnt_q   <= phase_cnt_d;
      high_tmp_q    <= high_tmp_d;
      meas_valid_q  <= meas_valid_d;
      high_len_q    <= high_len_d;
      period_q      <= period_d;
      period_min_q  <= period_min_d;
      period_max_q  <= period_max_d;
      meas_cnt_q    <= meas_cnt_d;
      stuck_q       <= stuck_d;
      stuck_level_q <= stuck_level_d;
    end
  end

  assign meas_valid  = meas_valid_q;
  assign high_len    = high_len_q;
  assign period      = period_q;
  assign period_min  = period_min_q;
  assign period_max  = period_max_q;
  assign meas_cnt    = meas_cnt_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_level_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor: directed scenarios plus random square waves, every
// cycle compared against an event/timestamp-level reference model.
module tb_clock_monitor;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 64;
  localparam int PMAX = (1 << (CNT_W + 1)) - 1;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             mon_in = 1'b0;
  logic             clr = 1'b0;
  logic             meas_valid;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W:0]   period;
  logic [CNT_W:0]   period_min;
  logic [CNT_W:0]   period_max;
  logic [CNT_W-1:0] meas_cnt;
  logic             stuck;
  logic             stuck_level;

  always #5 clk = ~clk;

  clock_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .mon_in(mon_in), .clr(clr),
    .meas_valid(meas_valid), .high_len(high_len), .period(period),
    .period_min(period_min), .period_max(period_max), .meas_cnt(meas_cnt),
    .stuck(stuck), .stuck_level(stuck_level)
  );

  int n_chk = 0;
  int n_bad = 0;
  int pulses = 0;

  // Reference model: mode 0 = waiting for a rise, 1 = timing high, 2 = timing low.
  bit q[3];
  int age, mode, hl;
  bit m_valid, m_stuck, m_level;
  int m_high, m_period, m_min, m_max, m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_edge();
    bit lvl, prv, r, f;
    if (rst) begin
      q = '{1'b0, 1'b0, 1'b0};
      age = 0; mode = 0; hl = 0;
      m_valid = 0; m_stuck = 0; m_level = 0;
      m_high = 0; m_period = 0; m_min = PMAX; m_max = 0; m_cnt = 0;
      return;
    end
    lvl = q[1];
    prv = q[2];
    r = lvl && !prv;
    f = !lvl && prv;
    m_valid = 0;
    if (clr) begin
      m_min = PMAX; m_max = 0; m_cnt = 0;
    end
    if (r) begin
      if (mode == 2) begin
        m_high = hl;
        m_period = hl + age;
        m_valid = 1;
        if (m_period < m_min) m_min = m_period;
        if (m_period > m_max) m_max = m_period;
        if (m_cnt < CMAX) m_cnt++;
      end
      mode = 1;
      m_stuck = 0;
    end else if (f) begin
      if (mode == 1 && !m_stuck) begin
        hl = age;
        mode = 2;
      end else begin
        mode = 0;
      end
      m_stuck = 0;
    end else if (!m_stuck && age == int'(TIMEOUT)) begin
      m_stuck = 1;
      m_level = lvl;
      mode = 0;
    end
    if (r || f) age = 1;
    else if (age < CMAX) age++;
    q[2] = q[1];
    q[1] = q[0];
    q[0] = mon_in;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("meas_valid", meas_valid, m_valid);
    chk("high_len", high_len, m_high);
    chk("period", period, m_period);
    chk("period_min", period_min, m_min);
    chk("period_max", period_max, m_max);
    chk("meas_cnt", meas_cnt, m_cnt);
    chk("stuck", stuck, m_stuck);
    chk("stuck_level", stuck_level, m_level);
    if (meas_valid === 1'b1) pulses++;
  endtask

  task automatic hold(input bit v, input int n);
    mon_in = v;
    repeat (n) tick();
  endtask

  task automatic sq(input int h, input int l, input int reps);
    repeat (reps) begin
      hold(1'b1, h);
      hold(1'b0, l);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    bit lvl;

    // Reset with mon_in toggling
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mon_in = ~mon_in;
      tick();
    end
    chk("t1_valid", meas_valid, 0);
    chk("t1_min", period_min, PMAX);
    chk("t1_max", period_max, 0);
    chk("t1_cnt", meas_cnt, 0);
    chk("t1_stuck", stuck, 0);
    rst = 1'b0;
    mon_in = 1'b0;

    // 5 high / 7 low, four periods
    pulses = 0;
    sq(5, 7, 4);
    hold(1'b0, 6);
    chk("t2_pulses", pulses, 3);
    chk("t2_high", high_len, 5);
    chk("t2_period", period, 12);
    chk("t2_min", period_min, 12);
    chk("t2_max", period_max, 12);
    chk("t2_cnt", meas_cnt, 3);

    // Periods 10, 20, 14 then clr coincident with a 16-cycle measurement
    do_reset(2);
    sq(5, 5, 1);
    sq(10, 10, 1);
    sq(7, 7, 1);
    hold(1'b1, 8);
    chk("t3_min", period_min, 10);
    chk("t3_max", period_max, 20);
    chk("t3_cnt", meas_cnt, 3);
    hold(1'b0, 8);
    mon_in = 1'b1;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t3_clr_valid", meas_valid, 1);
    chk("t3_clr_min", period_min, 16);
    chk("t3_clr_max", period_max, 16);
    chk("t3_clr_cnt", meas_cnt, 1);
    hold(1'b1, 5);
    hold(1'b0, 5);

    // Stuck high, then release
    do_reset(2);
    pulses = 0;
    mon_in = 1'b1;
    n = 0;
    while (stuck !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("t4_stuck_lat", n, 67);
    chk("t4_level", stuck_level, 1);
    mon_in = 1'b0;
    n = 0;
    while (stuck !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk("t4_release_lat", n, 3);
    hold(1'b0, 4);
    chk("t4_pulses", pulses, 0);
    sq(4, 4, 2);
    hold(1'b1, 4);

    // High at reset release, short first phase, then 4/4
    rst = 1'b1;
    mon_in = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    hold(1'b1, 3);
    hold(1'b0, 4);
    sq(4, 4, 3);
    hold(1'b1, 4);
    chk("t5_high", high_len, 4);
    chk("t5_period", period, 8);

    // Reset in the middle of a low phase
    do_reset(1);
    sq(6, 6, 2);
    hold(1'b1, 6);
    hold(1'b0, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_period", period, 0);
    chk("t6_rst_cnt", meas_cnt, 0);
    hold(1'b0, 3);
    pulses = 0;
    hold(1'b1, 6);
    hold(1'b0, 6);
    hold(1'b1, 4);
    chk("t6_pulses", pulses, 1);
    chk("t6_high", high_len, 6);
    chk("t6_period", period, 12);

    // Random phases with occasional timeouts, clears and resets
    do_reset(1);
    lvl = 1'b1;
    for (int seg = 0; seg < 60; seg++) begin
      n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 80)) : int'($urandom_range(1, 15));
      mon_in = lvl;
      repeat (n) begin
        clr = ($urandom_range(0, 15) == 0);
        rst = ($urandom_range(0, 199) == 0);
        tick();
      end
      lvl = !lvl;
    end
    clr = 1'b0;
    rst = 1'b0;
    hold(1'b0, 5);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
